// File: rtl/snoop_lookup_resp_md_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snoop_lookup_resp_md_if                                              |
// | Snoop request, set lookup and state-write bundle for one LV1 cache.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface snoop_lookup_resp_md_if #(
  parameter int ASSOC     = 4,
  parameter int ASSOC_WID = 2,
  parameter int TAG_WID   = 24
);
  logic                     snoop_req;
  logic [1:0]               snoop_type;
  logic [TAG_WID-1:0]       snoop_tag;
  logic [ASSOC*TAG_WID-1:0] way_tag_in;
  logic [2*ASSOC-1:0]       way_mesi_in;
  logic [ASSOC_WID-1:0]     blk_access_snoop;
  logic                     flush_done;
  logic                     blk_hit_snoop;
  logic [ASSOC-1:0]         access_blk_snoop;
  logic                     mesi_wr_en;
  logic [ASSOC_WID-1:0]     mesi_wr_way;
  logic [1:0]               mesi_wr_data;
  logic                     shared_out;
  logic                     flush_req;
  logic                     snoop_busy;
  logic                     snoop_done;

  modport master (
    output snoop_req, snoop_type, snoop_tag, way_tag_in, way_mesi_in,
           blk_access_snoop, flush_done,
    input  blk_hit_snoop, access_blk_snoop, mesi_wr_en, mesi_wr_way,
           mesi_wr_data, shared_out, flush_req, snoop_busy, snoop_done
  );

  modport slave (
    input  snoop_req, snoop_type, snoop_tag, way_tag_in, way_mesi_in,
           blk_access_snoop, flush_done,
    output blk_hit_snoop, access_blk_snoop, mesi_wr_en, mesi_wr_way,
           mesi_wr_data, shared_out, flush_req, snoop_busy, snoop_done
  );
endinterface
`default_nettype wire

// File: rtl/snoop_lookup_resp_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snoop_lookup_resp_md                                                 |
// | Snoop tag lookup, MESI update and flush sequencer for one LV1 cache. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module snoop_lookup_resp_md #(
  parameter int ASSOC     = 4,
  parameter int ASSOC_WID = 2,
  parameter int TAG_WID   = 24
) (
  input  wire logic              clk,
  input  wire logic              rst,
  snoop_lookup_resp_md_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_RESP   = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] MESI_I   = 2'b00;
  localparam logic [1:0] MESI_S   = 2'b01;
  localparam logic [1:0] MESI_M   = 2'b11;
  localparam logic [1:0] TYPE_RD  = 2'b00;
  localparam logic [1:0] TYPE_RDX = 2'b01;
  localparam logic [1:0] TYPE_INV = 2'b10;
  localparam logic [1:0] TYPE_RSV = 2'b11;

  state_t               state_q,   state_d;
  logic [1:0]           type_q,    type_d;
  logic [ASSOC-1:0]     vec_q,     vec_d;
  logic                 hit_q,     hit_d;
  logic [2*ASSOC-1:0]   mesi_q,    mesi_d;
  logic [ASSOC_WID-1:0] wr_way_q,  wr_way_d;
  logic [1:0]           wr_data_q, wr_data_d;
  logic                 flush_q,   flush_d;

  logic [ASSOC-1:0]     way_match;
  logic [1:0]           hit_mesi;
  logic [1:0]           next_mesi;
  logic                 need_flush;

  // A way only counts as a hit if its line is valid.
  for (genvar i = 0; i < ASSOC; i++) begin : g_match
    assign way_match[i] = (bus.way_tag_in[i*TAG_WID +: TAG_WID] == bus.snoop_tag) &&
                          (bus.way_mesi_in[2*i +: 2] != MESI_I);
  end

  assign hit_mesi = mesi_q[{bus.blk_access_snoop, 1'b0} +: 2];

  always_comb begin
    next_mesi  = MESI_I;
    need_flush = 1'b0;
    case (type_q)
      TYPE_RD: begin
        next_mesi  = (hit_mesi == MESI_I) ? MESI_I : MESI_S;
        need_flush = (hit_mesi == MESI_M);
      end
      TYPE_RDX: begin
        next_mesi  = MESI_I;
        need_flush = (hit_mesi == MESI_M);
      end
      TYPE_INV: begin
        next_mesi  = MESI_I;
        need_flush = 1'b0;
      end
      default: begin
        next_mesi  = MESI_I;
        need_flush = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    vec_d     = vec_q;
    hit_d     = hit_q;
    mesi_d    = mesi_q;
    wr_way_d  = wr_way_q;
    wr_data_d = wr_data_q;
    flush_d   = flush_q;
    case (state_q)
      S_IDLE: begin
        if (bus.snoop_req) begin
          type_d  = bus.snoop_type;
          vec_d   = way_match;
          hit_d   = |way_match;
          mesi_d  = bus.way_mesi_in;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!hit_q || (type_q == TYPE_RSV)) begin
          state_d = S_DONE;
        end else begin
          wr_way_d  = bus.blk_access_snoop;
          wr_data_d = next_mesi;
          flush_d   = need_flush;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = flush_q ? S_FLUSH : S_DONE;
      end
      S_FLUSH: begin
        if (bus.flush_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        vec_d   = '0;
        hit_d   = 1'b0;
        flush_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      type_q    <= 2'b00;
      vec_q     <= '0;
      hit_q     <= 1'b0;
      mesi_q    <= '0;
      wr_way_q  <= '0;
      wr_data_q <= 2'b00;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      vec_q     <= vec_d;
      hit_q     <= hit_d;
      mesi_q    <= mesi_d;
      wr_way_q  <= wr_way_d;
      wr_data_q <= wr_data_d;
      flush_q   <= flush_d;
    end
  end

  // Strobe-type outputs are pure state decodes so reset clears them at once.
  assign bus.blk_hit_snoop    = hit_q;
  assign bus.access_blk_snoop = vec_q;
  assign bus.mesi_wr_en       = (state_q == S_RESP);
  assign bus.mesi_wr_way      = (state_q == S_RESP) ? wr_way_q  : '0;
  assign bus.mesi_wr_data     = (state_q == S_RESP) ? wr_data_q : 2'b00;
  assign bus.shared_out       = (state_q == S_RESP);
  assign bus.flush_req        = (state_q == S_FLUSH);
  assign bus.snoop_busy       = (state_q != S_IDLE);
  assign bus.snoop_done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_snoop_lookup_resp_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_snoop_lookup_resp_md                                              |
// | Directed table-driven bench for the snoop lookup/response sequencer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_snoop_lookup_resp_md;

  localparam logic [1:0] I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11;
  localparam logic [23:0] T  = 24'hABC123;
  localparam logic [23:0] X0 = 24'h000010, X1 = 24'h000011;
  localparam logic [23:0] X2 = 24'h000012, X3 = 24'h000013;

  typedef struct {
    logic [1:0]  typ;
    logic [95:0] tags;
    logic [7:0]  mesi;
    logic [3:0]  exp_vec;
    logic        exp_resp;
    logic [1:0]  exp_way;
    logic [1:0]  exp_data;
    logic        exp_flush;
    int          fdelay;
    logic        noise;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [12];

  always #5 clk = ~clk;

  snoop_lookup_resp_md_if #(.ASSOC(4), .ASSOC_WID(2), .TAG_WID(24)) bus ();

  snoop_lookup_resp_md #(.ASSOC(4), .ASSOC_WID(2), .TAG_WID(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Snoop-side way encoder: lowest matching way wins.
  always_comb begin
    bus.blk_access_snoop = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.access_blk_snoop[i]) bus.blk_access_snoop = i[1:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(logic [1:0] typ, logic [95:0] tags, logic [7:0] mesi,
                               logic [3:0] ev, logic er, logic [1:0] ew, logic [1:0] ed,
                               logic ef, int fd, logic nz);
    vec_t v;
    v.typ = typ; v.tags = tags; v.mesi = mesi; v.exp_vec = ev; v.exp_resp = er;
    v.exp_way = ew; v.exp_data = ed; v.exp_flush = ef; v.fdelay = fd; v.noise = nz;
    return v;
  endfunction

  task automatic drive(input logic [1:0] typ, input logic [23:0] tag,
                       input logic [95:0] tags, input logic [7:0] mesi);
    bus.snoop_type  = typ;
    bus.snoop_tag   = tag;
    bus.way_tag_in  = tags;
    bus.way_mesi_in = mesi;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive(v.typ, T, v.tags, v.mesi);
    bus.snoop_req  = 1'b1;
    bus.flush_done = v.noise;
    tick();  // cycle 1: LOOKUP
    chk($sformatf("v%0d vec", idx), 32'(bus.access_blk_snoop), 32'(v.exp_vec));
    chk($sformatf("v%0d hit", idx), 32'(bus.blk_hit_snoop), 32'(|v.exp_vec));
    chk($sformatf("v%0d busy1", idx), 32'(bus.snoop_busy), 32'd1);
    chk($sformatf("v%0d done1", idx), 32'(bus.snoop_done), 32'd0);
    tick();  // cycle 2
    if (!v.exp_resp) begin
      chk($sformatf("v%0d miss_done2", idx), 32'(bus.snoop_done), 32'd1);
      chk($sformatf("v%0d miss_wr", idx), 32'(bus.mesi_wr_en), 32'd0);
      chk($sformatf("v%0d miss_shared", idx), 32'(bus.shared_out), 32'd0);
      chk($sformatf("v%0d miss_flush", idx), 32'(bus.flush_req), 32'd0);
    end else begin
      chk($sformatf("v%0d wr_en", idx), 32'(bus.mesi_wr_en), 32'd1);
      chk($sformatf("v%0d wr_way", idx), 32'(bus.mesi_wr_way), 32'(v.exp_way));
      chk($sformatf("v%0d wr_data", idx), 32'(bus.mesi_wr_data), 32'(v.exp_data));
      chk($sformatf("v%0d shared", idx), 32'(bus.shared_out), 32'd1);
      chk($sformatf("v%0d done2", idx), 32'(bus.snoop_done), 32'd0);
      tick();  // cycle 3
      bus.flush_done = 1'b0;
      if (v.exp_flush) begin
        for (int k = 0; k <= v.fdelay; k++) begin
          chk($sformatf("v%0d flush_req c%0d", idx, 3 + k), 32'(bus.flush_req), 32'd1);
          chk($sformatf("v%0d flush_done_early c%0d", idx, 3 + k), 32'(bus.snoop_done), 32'd0);
          if (k == v.fdelay) bus.flush_done = 1'b1;
          tick();
        end
        bus.flush_done = 1'b0;
      end
      chk($sformatf("v%0d done", idx), 32'(bus.snoop_done), 32'd1);
      chk($sformatf("v%0d done_noflush", idx), 32'(bus.flush_req), 32'd0);
    end
    chk($sformatf("v%0d done_nowr", idx), 32'(bus.mesi_wr_en), 32'd0);
    bus.snoop_req  = 1'b0;
    bus.flush_done = 1'b0;
    tick();  // back in IDLE
    chk($sformatf("v%0d idle_busy", idx), 32'(bus.snoop_busy), 32'd0);
    chk($sformatf("v%0d idle_vec", idx), 32'(bus.access_blk_snoop), 32'd0);
    chk($sformatf("v%0d idle_hit", idx), 32'(bus.blk_hit_snoop), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.snoop_req  = 1'b0;
    bus.flush_done = 1'b0;
    drive(2'b00, 24'h0, 96'h0, 8'h0);

    //           typ    tags {w3,w2,w1,w0}   mesi {w3,w2,w1,w0}  vec    resp way   data flush fd nz
    tbl[0]  = mkv(2'b00, {X3, T, X1, X0}, {M, E, S, E}, 4'b0100, 1, 2'd2, S, 0, 0, 0);
    tbl[1]  = mkv(2'b01, {T, X2, X1, X0}, {M, S, E, S}, 4'b1000, 1, 2'd3, I, 1, 3, 0);
    tbl[2]  = mkv(2'b00, {X3, X2, T, X0}, {S, S, I, S}, 4'b0000, 0, 2'd0, I, 0, 0, 0);
    tbl[3]  = mkv(2'b10, {X3, X2, X1, T}, {M, E, I, S}, 4'b0001, 1, 2'd0, I, 0, 0, 0);
    tbl[4]  = mkv(2'b11, {X3, T, X1, X0}, {I, M, I, I}, 4'b0100, 0, 2'd0, I, 0, 0, 0);
    tbl[5]  = mkv(2'b00, {X3, X2, X1, T}, {I, I, I, M}, 4'b0001, 1, 2'd0, S, 1, 0, 0);
    tbl[6]  = mkv(2'b01, {X3, X2, T, X0}, {I, I, S, I}, 4'b0010, 1, 2'd1, I, 0, 0, 0);
    tbl[7]  = mkv(2'b00, {X3, T, T, X0},  {I, E, S, I}, 4'b0110, 1, 2'd1, S, 0, 0, 0);
    tbl[8]  = mkv(2'b01, {X3, X2, X1, T}, {I, I, I, E}, 4'b0001, 1, 2'd0, I, 0, 0, 1);
    tbl[9]  = mkv(2'b10, {T, X2, X1, X0}, {M, I, I, I}, 4'b1000, 1, 2'd3, I, 0, 0, 0);
    tbl[10] = mkv(2'b01, {X3, T, X1, X0}, {I, M, I, I}, 4'b0100, 1, 2'd2, I, 1, 1, 1);
    tbl[11] = mkv(2'b00, {X3, X2, X1, X0}, {M, M, M, M}, 4'b0000, 0, 2'd0, I, 0, 0, 0);

    // Reset held, released with no request pending.
    tick();
    tick();
    chk("rst_busy", 32'(bus.snoop_busy), 32'd0);
    chk("rst_done", 32'(bus.snoop_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_outputs",
        {20'd0, bus.blk_hit_snoop, bus.access_blk_snoop, bus.mesi_wr_en, bus.mesi_wr_way,
         bus.mesi_wr_data, bus.shared_out, bus.flush_req, bus.snoop_busy, bus.snoop_done},
        32'd0);

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    // Request held while busy: inputs change mid-transaction, then stay asserted.
    drive(2'b10, T, {X3, X2, X1, T}, {I, I, S, S});
    bus.snoop_req = 1'b1;
    tick();
    drive(2'b00, X1, {X3, X2, X1, T}, {I, I, S, S});
    chk("busy_vec1", 32'(bus.access_blk_snoop), 32'b0001);
    tick();
    chk("busy_wr_way", 32'(bus.mesi_wr_way), 32'd0);
    chk("busy_wr_data", 32'(bus.mesi_wr_data), 32'(I));
    chk("busy_wr_en", 32'(bus.mesi_wr_en), 32'd1);
    tick();
    chk("busy_noflush", 32'(bus.flush_req), 32'd0);
    chk("busy_done", 32'(bus.snoop_done), 32'd1);
    tick();
    chk("b2b_idle", 32'(bus.snoop_busy), 32'd0);
    tick();
    chk("b2b_vec", 32'(bus.access_blk_snoop), 32'b0010);
    bus.snoop_req = 1'b0;
    tick();
    chk("b2b_wr_way", 32'(bus.mesi_wr_way), 32'd1);
    chk("b2b_wr_data", 32'(bus.mesi_wr_data), 32'(S));
    tick();
    chk("b2b_done", 32'(bus.snoop_done), 32'd1);
    tick();

    // Asynchronous reset in the middle of a flush.
    drive(2'b01, T, {T, X2, X1, X0}, {M, I, I, I});
    bus.snoop_req = 1'b1;
    tick();
    tick();
    tick();
    chk("rstf_flush_before", 32'(bus.flush_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstf_flush_async", 32'(bus.flush_req), 32'd0);
    chk("rstf_busy", 32'(bus.snoop_busy), 32'd0);
    chk("rstf_done", 32'(bus.snoop_done), 32'd0);
    chk("rstf_wr", 32'(bus.mesi_wr_en), 32'd0);
    chk("rstf_vec", 32'(bus.access_blk_snoop), 32'd0);
    bus.snoop_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstf_nodone c%0d", k), 32'(bus.snoop_done), 32'd0);
      chk($sformatf("rstf_nowr c%0d", k), 32'(bus.mesi_wr_en), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snoop_lookup_resp_md.md
# snoop_lookup_resp_md

Snoop-side lookup and response sequencer for one LV1 cache.
- Accepts a snoop request from the system bus (BusRd, BusRdX, Invalidate) and compares the snoop tag against every way of the indexed set.
- Drives the registered hit vector into the snoop-side way encoder and takes the encoded way back.
- Then writes the next MESI state, asserts shared, and runs the flush handshake when the hit line is Modified.

## Interface
Parameters:
- ASSOC, `ASSOC_LV1 (4): number of ways
- ASSOC_WID, `ASSOC_WID_LV1 (2): log2(ASSOC)
- TAG_WID, 24: tag width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- snoop_req  in  1  snoop request; sampled only in IDLE
- snoop_type  in  2  00 BusRd, 01 BusRdX, 10 Invalidate, 11 reserved (treated as no-op miss)
- snoop_tag  in  TAG_WID  tag of snooped address
- way_tag_in  in  ASSOC*TAG_WID  tags of indexed set; way i at [i*TAG_WID +: TAG_WID]
- way_mesi_in  in  2*ASSOC  MESI of indexed set, way i at [2i +: 2]; I=00, S=01, E=10, M=11
- blk_access_snoop  in  ASSOC_WID  encoded way returned by the encoder
- flush_done  in  1  bus has taken the flushed line
- blk_hit_snoop  out  1  registered: some valid way matched
- access_blk_snoop  out  ASSOC  registered one-hot/multi-hot match vector
- mesi_wr_en  out  1  one-cycle state-array write strobe
- mesi_wr_way  out  ASSOC_WID  way to write
- mesi_wr_data  out  2  new MESI state
- shared_out  out  1  snoop hit on a valid line (one cycle)
- flush_req  out  1  request to drive line onto bus; held until flush_done
- snoop_busy  out  1  high in every state except IDLE
- snoop_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOOKUP, RESP, FLUSH, DONE.
- IDLE, snoop_req=1:
  - Latch snoop_type.
  - Compute way match as tag equal AND MESI != I.
  - Register the match vector into access_blk_snoop, its OR into blk_hit_snoop, and all way MESI values.
  - Go to LOOKUP.
- LOOKUP:
  - Miss or reserved type: go to DONE; no write, no shared.
  - Hit: latch blk_access_snoop and the MESI of that way; compute next state; go to RESP.
- Next state:
  - BusRd: M->S with flush; E->S; S->S.
  - BusRdX: M->I with flush; E->I; S->I.
  - Invalidate: any->I, never flush.
- RESP:
  - mesi_wr_en=1 with way and data; shared_out=1.
  - Flush needed: go to FLUSH; otherwise go to DONE.
- FLUSH: flush_req=1 every cycle; on flush_done=1 go to DONE.
- DONE: snoop_done=1, clear access_blk_snoop and blk_hit_snoop, go to IDLE.
- snoop_req in any state other than IDLE is ignored; the bus must hold it until snoop_done.
- flush_done outside FLUSH is ignored.
- Multiple matching ways (corrupt state): the vector passes through unchanged; the encoder's chosen way is the only one updated.

## Timing
- Reset: all outputs 0, state IDLE; takes effect immediately mid-operation.
  - A pending flush is abandoned with no snoop_done.
  - No state write is issued.
- access_blk_snoop and blk_hit_snoop are valid in LOOKUP, one cycle after request acceptance.
- blk_access_snoop must be valid combinationally in that same cycle.
- Latency, request accepted at cycle 0:
  - Miss: snoop_done at cycle 2.
  - Hit without flush: mesi_wr_en at cycle 2, snoop_done at cycle 3.
  - Hit with flush: mesi_wr_en at cycle 2; flush_req from cycle 3.
- flush_done is accepted in the first FLUSH cycle; flush_done at cycle n gives snoop_done at n+1.
- Back-to-back: a new request can be accepted in the cycle after snoop_done.

## Test plan
- Reset held, then released with snoop_req=0: all outputs 0, snoop_busy=0; rst pulsed during FLUSH -> flush_req drops asynchronously, no snoop_done.
- BusRd, tag matches way 2 in E:
  - Cycle 1: access_blk_snoop=0100, blk_hit_snoop=1.
  - Cycle 2: mesi_wr_en=1, way=2, data=01, shared_out=1.
  - Cycle 3: snoop_done=1.
- BusRdX, tag matches way 3 in M:
  - Cycle 2: write way 3 data=00.
  - flush_req high from cycle 3; flush_done at cycle 6 -> snoop_done at cycle 7.
- BusRd, tag matches only way 1, which is in I: blk_hit_snoop=0, no mesi_wr_en, no shared_out, snoop_done at cycle 2.
- Invalidate on a way-0 S hit -> write way 0 data=00 with no flush_req.
  - A second snoop_req asserted while busy is ignored until IDLE.
- Reserved type 11 with a tag match on an M way: treated as a miss, no write, no flush_req, snoop_done at cycle 2.
